exc_ctrl: RTL and testbench

Exception/interrupt sequencer sitting at the commit (MEM/WB boundary) stage, directly in front of cp0.
- Prioritises the exception flags carried by the committing instruction and merges in the pending-interrupt indication from cp0.
- Issues exactly one exception or eret event per trap to cp0.
- Then drives a multi-cycle pipeline flush and a front-end PC redirect to the handler vector or to EPC.

---
 rtl/exc_ctrl_pkg.sv | 17 +
 rtl/exc_prio.sv | 25 ++
 rtl/exc_ctrl.sv | 123 ++++++++++++
 tb/tb_exc_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg: excode constants, Status bit index, FSM states and shared helpers for exc_ctrl
package exc_ctrl_pkg;
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam int STATUS_BEV = 22;
  typedef enum logic {EXCC_IDLE = 1'b0, EXCC_FLUSH = 1'b1} state_t;
  typedef enum logic [1:0] {BVA_NONE, BVA_PC, BVA_VADDR} bva_sel_t;
  // EPC points at the branch when the faulting instruction sits in its delay slot
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? pc - 32'd4 : pc;
  endfunction
endpackage

// File: rtl/exc_prio.sv
// exc_prio: combinational priority encoder from commit exception flags to {hit, excode, badvaddr source}
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  logic       int_take,
  input  logic       if_adel,
  input  logic       ri,
  input  logic       ov,
  input  logic       sys,
  input  logic       bp,
  input  logic       mem_adel,
  input  logic       mem_ades,
  output logic       hit,
  output logic [4:0] excode,
  output bva_sel_t   bva_sel
);
  // highest-priority flag wins; the interrupt outranks every synchronous exception
  always_comb begin
    hit = int_take | if_adel | ri | ov | sys | bp | mem_adel | mem_ades;
    excode = int_take ? EXC_INT : if_adel ? EXC_ADEL : ri ? EXC_RI : ov ? EXC_OV :
             sys ? EXC_SYS : bp ? EXC_BP : mem_adel ? EXC_ADEL : mem_ades ? EXC_ADES : EXC_INT;
    bva_sel = int_take ? BVA_NONE : if_adel ? BVA_PC : (ri | ov | sys | bp) ? BVA_NONE :
              (mem_adel | mem_ades) ? BVA_VADDR : BVA_NONE;
  end
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: commit-stage exception/interrupt sequencer feeding cp0, then flushing and redirecting (optional stats: EXC_CTRL_STATS_EN)
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] VEC_BEV1 = 32'hBFC00380,
  parameter logic [31:0] VEC_BEV0 = 32'h80000180
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cm_valid,
  input  logic [31:0] cm_pc,
  input  logic        cm_bd,
  input  logic        cm_if_adel,
  input  logic        cm_ri,
  input  logic        cm_sys,
  input  logic        cm_bp,
  input  logic        cm_ov,
  input  logic        cm_mem_adel,
  input  logic        cm_mem_ades,
  input  logic [31:0] cm_vaddr,
  input  logic        cm_eret,
  input  logic        cm_mtc0_sr,
  input  logic        int_pending,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_epc,
  output logic        exc_valid,
  output logic [4:0]  exc_excode,
  output logic        exc_bd,
  output logic [31:0] exc_epc,
  output logic [31:0] exc_badvaddr,
  output logic        exc_eret,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
`ifdef EXC_CTRL_STATS_EN
  ,
  output logic [31:0] trap_count,
  output logic [31:0] int_count
`endif
);
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic mask;
  logic active, take_int, trap, eret_ev, hit;
  logic [4:0] p_excode;
  bva_sel_t bva_sel;
  logic unused_status;
  assign unused_status = ^{cp0_status[31:STATUS_BEV+1], cp0_status[STATUS_BEV-1:0]};
  assign active = (state == EXCC_IDLE) & cm_valid;
  assign take_int = active & int_pending & ~mask;
  exc_prio u_prio (
    .int_take (take_int),
    .if_adel  (cm_if_adel),
    .ri       (cm_ri),
    .ov       (cm_ov),
    .sys      (cm_sys),
    .bp       (cm_bp),
    .mem_adel (cm_mem_adel),
    .mem_ades (cm_mem_ades),
    .hit      (hit),
    .excode   (p_excode),
    .bva_sel  (bva_sel)
  );
  // cp0 event for the committing instruction; eret only when nothing outranks it
  always_comb begin
    trap = active & hit;
    eret_ev = active & cm_eret & ~trap;
    exc_valid = trap | eret_ev;
    exc_eret = eret_ev;
    exc_excode = trap ? p_excode : EXC_INT;
    exc_bd = trap & cm_bd;
    exc_epc = trap ? epc_of(cm_pc, cm_bd) : 32'd0;
    exc_badvaddr = !trap ? 32'd0 : bva_sel == BVA_PC ? cm_pc : bva_sel == BVA_VADDR ? cm_vaddr : 32'd0;
  end
  // next state: enter FLUSH on any event, count down the flush window, then back to IDLE
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (state == EXCC_IDLE) begin
      if (exc_valid) begin
        state_nx = EXCC_FLUSH;
        cnt_nx = 4'(FLUSH_CYCLES);
      end
    end else begin
      cnt_nx = cnt - 4'd1;
      if (cnt <= 4'd1) begin
        state_nx = EXCC_IDLE;
        cnt_nx = 4'd0;
      end
    end
  end
  // state, flush counter, interrupt mask window and the one-shot redirect
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= EXCC_IDLE;
      cnt <= 4'd0;
      mask <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      mask <= cm_valid & cm_mtc0_sr;
      redirect_valid <= exc_valid;
      if (exc_valid)
        redirect_pc <= eret_ev ? cp0_epc : cp0_status[STATUS_BEV] ? VEC_BEV1 : VEC_BEV0;
    end
  end
  assign flush = state == EXCC_FLUSH;
`ifdef EXC_CTRL_STATS_EN
  // wrapping trap and interrupt event counters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      trap_count <= 32'd0;
      int_count <= 32'd0;
    end else begin
      trap_count <= trap_count + {31'd0, trap};
      int_count <= int_count + {31'd0, take_int};
    end
  end
`endif
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: table vectors, corner sequences and randomized commits checked against a behavioural model
module tb_exc_ctrl;
  localparam int FC = 2;
  localparam logic [31:0] V1 = 32'hBFC00380, V0 = 32'h80000180, BEV = 32'h0040_0000;
  typedef struct packed {
    logic valid; logic [31:0] pc; logic bd, if_adel, ri, sys, bp, ov, adel, ades;
    logic [31:0] vaddr; logic eret, mtc0, intp; logic [31:0] status, epc;
  } cm_t;
  typedef struct {
    cm_t c; logic v; logic [4:0] ec; logic er, bd; logic [31:0] epc, bva, rpc;
  } vec_t;
  typedef struct {
    logic v; logic [4:0] ec; logic er, bd; logic [31:0] epc, bva;
  } out_t;
  logic clk = 0, resetn = 0;
  cm_t drv = '0;
  logic exc_valid, exc_bd, exc_eret, flush, redirect_valid;
  logic [4:0] exc_excode;
  logic [31:0] exc_epc, exc_badvaddr, redirect_pc;
`ifdef EXC_CTRL_STATS_EN
  logic [31:0] trap_count, int_count;
`endif
  int compared = 0, mismatched = 0;
  int m_busy = 0;
  logic m_mask = 0, m_rv = 0;
  logic [31:0] m_rpc = 0;
  vec_t tbl[13];
  always #5 clk = ~clk;
  exc_ctrl dut (
    .clk(clk), .resetn(resetn), .cm_valid(drv.valid), .cm_pc(drv.pc), .cm_bd(drv.bd),
    .cm_if_adel(drv.if_adel), .cm_ri(drv.ri), .cm_sys(drv.sys), .cm_bp(drv.bp), .cm_ov(drv.ov),
    .cm_mem_adel(drv.adel), .cm_mem_ades(drv.ades), .cm_vaddr(drv.vaddr), .cm_eret(drv.eret),
    .cm_mtc0_sr(drv.mtc0), .int_pending(drv.intp), .cp0_status(drv.status), .cp0_epc(drv.epc),
    .exc_valid(exc_valid), .exc_excode(exc_excode), .exc_bd(exc_bd), .exc_epc(exc_epc),
    .exc_badvaddr(exc_badvaddr), .exc_eret(exc_eret), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef EXC_CTRL_STATS_EN
    , .trap_count(trap_count), .int_count(int_count)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // reference: what cp0 should see, straight from the priority list
  function automatic out_t ref_out(input cm_t x, input logic idle, input logic msk);
    out_t o = '{v: 0, ec: 0, er: 0, bd: 0, epc: 0, bva: 0};
    logic [31:0] e = x.bd ? x.pc - 32'd4 : x.pc;
    if (!idle || !x.valid) return o;
    o = '{v: 1, ec: 0, er: 0, bd: x.bd, epc: e, bva: 0};
    if (x.intp && !msk) o.ec = 5'h00;
    else if (x.if_adel) begin o.ec = 5'h04; o.bva = x.pc; end
    else if (x.ri) o.ec = 5'h0a;
    else if (x.ov) o.ec = 5'h0c;
    else if (x.sys) o.ec = 5'h08;
    else if (x.bp) o.ec = 5'h09;
    else if (x.adel) begin o.ec = 5'h04; o.bva = x.vaddr; end
    else if (x.ades) begin o.ec = 5'h05; o.bva = x.vaddr; end
    else if (x.eret) o = '{v: 1, ec: 0, er: 1, bd: 0, epc: 0, bva: 0};
    else o = '{v: 0, ec: 0, er: 0, bd: 0, epc: 0, bva: 0};
    return o;
  endfunction
  // one clock: apply inputs, compare everything against the model, advance model and DUT
  task automatic step(input cm_t x);
    out_t o;
    drv = x;
    #1;
    o = ref_out(x, m_busy == 0, m_mask);
    chk("exc_valid", 32'(exc_valid), 32'(o.v));
    chk("exc_excode", 32'(exc_excode), 32'(o.ec));
    chk("exc_eret", 32'(exc_eret), 32'(o.er));
    chk("exc_bd", 32'(exc_bd), 32'(o.bd));
    chk("exc_epc", exc_epc, o.epc);
    chk("exc_badvaddr", exc_badvaddr, o.bva);
    chk("flush", 32'(flush), 32'(m_busy > 0));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    chk("redirect_pc", redirect_pc, m_rpc);
    if (!resetn) begin
      m_busy = 0; m_mask = 0; m_rv = 0; m_rpc = 0;
    end else begin
      m_mask = x.valid & x.mtc0;
      m_rv = o.v;
      if (o.v) begin
        m_busy = FC;
        m_rpc = o.er ? x.epc : x.status[22] ? V1 : V0;
      end else if (m_busy > 0) m_busy--;
    end
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mkv(input cm_t c, input logic v, input logic [4:0] ec, input logic er,
                               input logic bd, input logic [31:0] epc, bva, rpc);
    return '{c: c, v: v, ec: ec, er: er, bd: bd, epc: epc, bva: bva, rpc: rpc};
  endfunction
  initial begin
    cm_t idle = '0, x;
    tbl[0]  = mkv('{valid: 1, pc: 32'hBFC00100, sys: 1, status: BEV, default: 0}, 1, 5'h08, 0, 0, 32'hBFC00100, 0, V1);
    tbl[1]  = mkv('{valid: 1, pc: 32'h80000204, bd: 1, ades: 1, vaddr: 32'h80001003, default: 0}, 1, 5'h05, 0, 1, 32'h80000200, 32'h80001003, V0);
    tbl[2]  = mkv('{valid: 1, pc: 32'h80000400, eret: 1, epc: 32'h80000340, status: BEV, default: 0}, 1, 5'h00, 1, 0, 0, 0, 32'h80000340);
    tbl[3]  = mkv('{valid: 1, pc: 32'h80000010, ri: 1, intp: 1, default: 0}, 1, 5'h00, 0, 0, 32'h80000010, 0, V0);
    tbl[4]  = mkv('{valid: 1, pc: 32'h80000003, if_adel: 1, ri: 1, status: BEV, default: 0}, 1, 5'h04, 0, 0, 32'h80000003, 32'h80000003, V1);
    tbl[5]  = mkv('{valid: 1, pc: 32'h80000020, ri: 1, ov: 1, sys: 1, default: 0}, 1, 5'h0a, 0, 0, 32'h80000020, 0, V0);
    tbl[6]  = mkv('{valid: 1, pc: 32'h80000024, ov: 1, sys: 1, bp: 1, default: 0}, 1, 5'h0c, 0, 0, 32'h80000024, 0, V0);
    tbl[7]  = mkv('{valid: 1, pc: 32'h80000028, bp: 1, adel: 1, vaddr: 32'h1234, default: 0}, 1, 5'h09, 0, 0, 32'h80000028, 0, V0);
    tbl[8]  = mkv('{valid: 1, pc: 32'h8000002c, adel: 1, ades: 1, vaddr: 32'h11, status: BEV, default: 0}, 1, 5'h04, 0, 0, 32'h8000002c, 32'h11, V1);
    tbl[9]  = mkv('{valid: 1, pc: 32'h0, bd: 1, sys: 1, default: 0}, 1, 5'h08, 0, 1, 32'hFFFFFFFC, 0, V0);
    tbl[10] = mkv('{valid: 1, pc: 32'h80000030, eret: 1, intp: 1, epc: 32'h80000777, default: 0}, 1, 5'h00, 0, 0, 32'h80000030, 0, V0);
    tbl[11] = mkv('{valid: 1, pc: 32'h80000034, eret: 1, ades: 1, vaddr: 32'h2, epc: 32'h80000777, default: 0}, 1, 5'h05, 0, 0, 32'h80000034, 32'h2, V0);
    tbl[12] = mkv('{valid: 0, pc: 32'h80000038, sys: 1, intp: 1, default: 0}, 0, 5'h00, 0, 0, 0, 0, 0);
    resetn = 0;
    step(idle);
    step(idle);
    chk("reset_flush", 32'(flush), 0);
    chk("reset_redirect_valid", 32'(redirect_valid), 0);
    chk("reset_redirect_pc", redirect_pc, 0);
    resetn = 1;
    for (int i = 0; i < 13; i++) begin
      for (int k = 0; k < 4; k++) step(idle);
      drv = tbl[i].c;
      #1;
      chk($sformatf("t%0d_valid", i), 32'(exc_valid), 32'(tbl[i].v));
      chk($sformatf("t%0d_excode", i), 32'(exc_excode), 32'(tbl[i].ec));
      chk($sformatf("t%0d_eret", i), 32'(exc_eret), 32'(tbl[i].er));
      chk($sformatf("t%0d_bd", i), 32'(exc_bd), 32'(tbl[i].bd));
      chk($sformatf("t%0d_epc", i), exc_epc, tbl[i].epc);
      chk($sformatf("t%0d_badvaddr", i), exc_badvaddr, tbl[i].bva);
      step(tbl[i].c);
      chk($sformatf("t%0d_rv", i), 32'(redirect_valid), 32'(tbl[i].v));
      chk($sformatf("t%0d_flush1", i), 32'(flush), 32'(tbl[i].v));
      if (tbl[i].v) chk($sformatf("t%0d_rpc", i), redirect_pc, tbl[i].rpc);
      step(idle);
      chk($sformatf("t%0d_rv_once", i), 32'(redirect_valid), 0);
      chk($sformatf("t%0d_flush2", i), 32'(flush), 32'(tbl[i].v));
      step(idle);
      chk($sformatf("t%0d_flush_end", i), 32'(flush), 0);
    end
    for (int k = 0; k < 4; k++) step(idle);
    step('{valid: 1, pc: 32'h80000100, mtc0: 1, default: 0});
    x = '{valid: 1, pc: 32'h80000104, intp: 1, default: 0};
    drv = x;
    #1;
    chk("mask_no_int", 32'(exc_valid), 0);
    step(x);
    x.pc = 32'h80000108;
    drv = x;
    #1;
    chk("mask_int_after", 32'(exc_valid), 1);
    chk("mask_int_excode", 32'(exc_excode), 0);
    chk("mask_int_epc", exc_epc, 32'h80000108);
    step(x);
    for (int k = 0; k < 4; k++) step(idle);
    x = '{valid: 1, pc: 32'hBFC00100, sys: 1, status: BEV, default: 0};
    step(x);
    drv = x;
    #1;
    chk("flush_ignores_commit", 32'(exc_valid), 0);
    resetn = 0;
    step(x);
    chk("reset_mid_flush", 32'(flush), 0);
    resetn = 1;
    step(idle);
    for (int n = 0; n < 600; n++) begin
      x = '0;
      x.valid = $urandom_range(0, 3) != 0;
      x.pc = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
      x.bd = $urandom_range(0, 1) == 1;
      x.if_adel = $urandom_range(0, 9) == 0;
      x.ri = $urandom_range(0, 9) == 0;
      x.sys = $urandom_range(0, 9) == 0;
      x.bp = $urandom_range(0, 9) == 0;
      x.ov = $urandom_range(0, 9) == 0;
      x.adel = $urandom_range(0, 9) == 0;
      x.ades = $urandom_range(0, 9) == 0;
      x.vaddr = $urandom;
      x.eret = $urandom_range(0, 5) == 0;
      x.mtc0 = $urandom_range(0, 3) == 0;
      x.intp = $urandom_range(0, 3) == 0;
      x.status = $urandom;
      x.epc = $urandom;
      resetn = $urandom_range(0, 49) != 0;
      step(x);
    end
    resetn = 1;
    step(idle);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
